// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, load-use stall,
// taken-branch flush, multi-cycle execute stall FSM and saturating perf counters.
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned EX_LAT   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              MemReadE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MulDivE,
    input  logic              CntClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              BubbleM,
    output logic              ExBusy,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam bit              MultiCycle = (EX_LAT > 1);
    // First BUSY cycle already counts as the second cycle of occupancy.
    localparam logic [7:0]      CntInit    = MultiCycle ? 8'(EX_LAT - 2) : 8'd0;
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ex_stall;
    logic             lw_stall;
    logic             rs1e_zero, rs2e_zero, rde_zero;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Forwarding select: M stage wins over W stage, register 0 never forwarded.
    always_comb begin
        rs1e_zero = ZERO_REG && (Rs1E == '0);
        rs2e_zero = ZERO_REG && (Rs2E == '0);
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rs1e_zero) begin
            if (RegWriteM && (RdM == Rs1E))      fwd_a = 2'b10;
            else if (RegWriteW && (RdW == Rs1E)) fwd_a = 2'b01;
        end
        if (!rs2e_zero) begin
            if (RegWriteM && (RdM == Rs2E))      fwd_b = 2'b10;
            else if (RegWriteW && (RdW == Rs2E)) fwd_b = 2'b01;
        end
    end

    // Load-use hazard; a taken branch squashes the dependent instruction anyway.
    always_comb begin
        rde_zero = ZERO_REG && (RdE == '0);
        lw_stall = MemReadE && ((RdE == Rs1D) || (RdE == Rs2D)) && !rde_zero && !PCSrcE;
    end

    // Multi-cycle FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multi-cycle FSM next state: release from BUSY goes to IDLE without re-triggering.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (MulDivE && MultiCycle) begin
                    state_d = StBusy;
                    cnt_d   = CntInit;
                end
            end
            StBusy: begin
                if (cnt_q != 8'd0) cnt_d   = cnt_q - 8'd1;
                else               state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Multi-cycle FSM output: stall E while the op still needs more cycles.
    always_comb begin
        ex_stall = 1'b0;
        unique case (state_q)
            StIdle:  ex_stall = MulDivE && MultiCycle;
            StBusy:  ex_stall = (cnt_q != 8'd0);
            default: ex_stall = 1'b0;
        endcase
    end

    // Pipeline controls; a held E stage is never flushed, everything quiet in reset.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        BubbleM   = 1'b0;
        ExBusy    = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            StallF    = lw_stall | ex_stall;
            StallD    = lw_stall | ex_stall;
            StallE    = ex_stall;
            BubbleM   = ex_stall;
            FlushD    = PCSrcE & ~ex_stall;
            FlushE    = (lw_stall | PCSrcE) & ~ex_stall;
            ExBusy    = (state_q == StBusy);
        end
    end

    // Saturating perf counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || CntClr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CntOne;
            if (FlushD && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CntOne;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus random
// stimulus, all compared cycle by cycle against a behavioural model.
module tb_hazard_ctrl_unit;

    localparam int unsigned AW  = 5;
    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          MemReadE, RegWriteM, RegWriteW, PCSrcE, MulDivE, CntClr;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, FlushD, FlushE, BubbleM, ExBusy;
    logic [CW-1:0] StallCnt, FlushCnt;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: cycles the current mul/div op has already held E (0 = none).
    int elapsed = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;
    int obs_stall_e = 0;
    int obs_busy = 0;

    hazard_ctrl_unit #(
        .REG_AW   (AW),
        .EX_LAT   (LAT),
        .CNT_W    (CW),
        .ZERO_REG (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RdM       (RdM),
        .RdW       (RdW),
        .MemReadE  (MemReadE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .PCSrcE    (PCSrcE),
        .MulDivE   (MulDivE),
        .CntClr    (CntClr),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .BubbleM   (BubbleM),
        .ExBusy    (ExBusy),
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [AW-1:0] src);
        if (src == 0) return 2'b00;
        if (RegWriteM && RdM == src) return 2'b10;
        if (RegWriteW && RdW == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        MemReadE = 0; RegWriteM = 0; RegWriteW = 0;
        PCSrcE = 0; MulDivE = 0; CntClr = 0;
    endtask

    // Check every output for the current cycle, then advance model and clock.
    task automatic cycle();
        logic ex, lw, stall, fd, fe, busy;
        logic [1:0] fa, fb;
        #2;
        if (elapsed == 0) ex = MulDivE && (LAT > 1);
        else              ex = (elapsed + 1 < LAT);
        busy = (elapsed != 0);
        lw = MemReadE && (RdE == Rs1D || RdE == Rs2D) && (RdE != 0) && !PCSrcE;
        fa = model_fwd(Rs1E);
        fb = model_fwd(Rs2E);
        stall = lw || ex;
        fd = PCSrcE && !ex;
        fe = (lw || PCSrcE) && !ex;
        if (rst) begin
            ex = 0; busy = 0; stall = 0; fd = 0; fe = 0; fa = 0; fb = 0;
        end
        check_eq("ForwardAE", 32'(ForwardAE), 32'(fa));
        check_eq("ForwardBE", 32'(ForwardBE), 32'(fb));
        check_eq("StallF", 32'(StallF), 32'(stall));
        check_eq("StallD", 32'(StallD), 32'(stall));
        check_eq("StallE", 32'(StallE), 32'(ex));
        check_eq("BubbleM", 32'(BubbleM), 32'(ex));
        check_eq("FlushD", 32'(FlushD), 32'(fd));
        check_eq("FlushE", 32'(FlushE), 32'(fe));
        check_eq("ExBusy", 32'(ExBusy), 32'(busy));
        check_eq("StallCnt", 32'(StallCnt), 32'(m_stall_cnt));
        check_eq("FlushCnt", 32'(FlushCnt), 32'(m_flush_cnt));
        obs_stall_e += int'(StallE);
        obs_busy    += int'(ExBusy);
        // Advance model
        if (rst) begin
            elapsed = 0;
        end else if (elapsed == 0) begin
            if (MulDivE && LAT > 1) elapsed = 1;
        end else begin
            elapsed = (elapsed + 1 == LAT) ? 0 : elapsed + 1;
        end
        if (rst || CntClr) begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            if (stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
            if (fd && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 0;

        // Forwarding priority and register-0 suppression
        Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
        #1 check_eq("fwd_m", 32'(ForwardAE), 32'd2);
        cycle();
        RegWriteM = 0;
        #1 check_eq("fwd_w", 32'(ForwardAE), 32'd1);
        cycle();
        RegWriteM = 1; Rs1E = 0; RdM = 0; RdW = 0;
        #1 check_eq("fwd_zero", 32'(ForwardAE), 32'd0);
        cycle();
        clear_inputs();

        // Load-use stall
        MemReadE = 1; RdE = 7; Rs2D = 7;
        #1 check_eq("lw_stallf", 32'(StallF), 32'd1);
        check_eq("lw_flushd", 32'(FlushD), 32'd0);
        cycle();
        MemReadE = 0;
        #1 check_eq("lw_cnt", 32'(StallCnt), 32'd1);
        cycle();
        MemReadE = 1; RdE = 0; Rs2D = 0;
        #1 check_eq("lw_rd0", 32'(StallF), 32'd0);
        cycle();

        // Taken branch overrides load-use
        MemReadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
        #1 check_eq("br_stallf", 32'(StallF), 32'd0);
        check_eq("br_flushe", 32'(FlushE), 32'd1);
        cycle();
        clear_inputs();
        cycle();

        // Single mul/div op
        obs_stall_e = 0; obs_busy = 0;
        MulDivE = 1;
        repeat (LAT) cycle();
        MulDivE = 0;
        check_eq("md_stalls", 32'(obs_stall_e), 32'(LAT - 1));
        check_eq("md_busy", 32'(obs_busy), 32'(LAT - 1));
        cycle();

        // Back-to-back ops, with a branch arriving while E is held
        obs_stall_e = 0;
        MulDivE = 1;
        cycle();
        PCSrcE = 1;
        #1 check_eq("md_noflush", 32'(FlushD), 32'd0);
        cycle();
        PCSrcE = 0;
        repeat (2 * LAT - 2) cycle();
        MulDivE = 0;
        check_eq("md_b2b", 32'(obs_stall_e), 32'(2 * (LAT - 1)));
        cycle();

        // Reset in the second BUSY cycle
        MulDivE = 1;
        repeat (2) cycle();
        rst = 1;
        #1 check_eq("rst_stalle", 32'(StallE), 32'd0);
        cycle();
        rst = 0; MulDivE = 0;
        #1 check_eq("rst_idle", 32'(ExBusy), 32'd0);
        cycle();

        // Counter saturation then clear with stall still present
        MemReadE = 1; RdE = 7; Rs1D = 7;
        repeat (20) cycle();
        check_eq("sat", 32'(StallCnt), 32'(CNT_MAX));
        CntClr = 1;
        cycle();
        CntClr = 0;
        #1 check_eq("clr", 32'(StallCnt), 32'd0);
        cycle();
        clear_inputs();

        // Random traffic, indices kept small so hazards are frequent
        for (int i = 0; i < 1500; i++) begin
            Rs1D = AW'($urandom_range(0, 7));
            Rs2D = AW'($urandom_range(0, 7));
            Rs1E = AW'($urandom_range(0, 7));
            Rs2E = AW'($urandom_range(0, 7));
            RdE  = AW'($urandom_range(0, 7));
            RdM  = AW'($urandom_range(0, 7));
            RdW  = AW'($urandom_range(0, 7));
            MemReadE  = ($urandom_range(0, 2) == 0);
            RegWriteM = $urandom_range(0, 1) == 1;
            RegWriteW = $urandom_range(0, 1) == 1;
            PCSrcE    = ($urandom_range(0, 5) == 0);
            MulDivE   = ($urandom_range(0, 5) == 0);
            CntClr    = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
